// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shifts and rotates,
// performed as one single-bit step per enabled clock with a start/busy/done handshake.
module universal_shift_reg #(
   parameter int unsigned  WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CW-1:0]    amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] out,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_SHL  = 3'd0;
   localparam logic [2:0] M_SHR  = 3'd1;
   localparam logic [2:0] M_ROL  = 3'd2;
   localparam logic [2:0] M_ROR  = 3'd3;
   localparam logic [2:0] M_ASR  = 3'd4;
   localparam logic [2:0] M_LOAD = 3'd5;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic [WIDTH-1:0] out_d;
   logic             sout_l_d, sout_r_d, done_d;
   logic             cmd_imm_c;

   // Commands that complete in IDLE without entering SHIFT
   assign cmd_imm_c = (mode == M_LOAD) || (amt == CW'(0)) || (mode[2:1] == 2'b11);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && en && !cmd_imm_c) state_d = S_SHIFT;
         S_SHIFT: if (en && (cnt_q == CW'(1)))    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_d    = out;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      sout_l_d = sout_l;
      sout_r_d = sout_r;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && en) begin
               if (mode == M_LOAD) begin
                  out_d  = load_data;
                  done_d = 1'b1;
               end else if (cmd_imm_c) begin
                  done_d = 1'b1;
               end else begin
                  mode_d = mode;
                  cnt_d  = amt;
               end
            end
         end
         S_SHIFT: begin
            if (en) begin
               cnt_d  = cnt_q - CW'(1);
               done_d = (cnt_q == CW'(1));
               case (mode_q)
                  M_SHL: begin out_d = {out[WIDTH-2:0], sin_l};      sout_l_d = out[WIDTH-1]; end
                  M_SHR: begin out_d = {sin_r, out[WIDTH-1:1]};      sout_r_d = out[0];       end
                  M_ROL: begin out_d = {out[WIDTH-2:0], out[WIDTH-1]}; sout_l_d = out[WIDTH-1]; end
                  M_ROR: begin out_d = {out[0], out[WIDTH-1:1]};     sout_r_d = out[0];       end
                  M_ASR: begin out_d = {out[WIDTH-1], out[WIDTH-1:1]}; sout_r_d = out[0];     end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   // Datapath and handshake registers; busy mirrors the next FSM state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out    <= '0;
         cnt_q  <= '0;
         mode_q <= M_SHL;
         sout_l <= 1'b0;
         sout_r <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         out    <= out_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         sout_l <= sout_l_d;
         sout_r <= sout_r_d;
         busy   <= (state_d == S_SHIFT);
         done   <= done_d;
      end
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8) with a reference model feeding
// an expected-result queue that is drained on each done pulse.
module tb_universal_shift_reg;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rstn, en, start, sin_l, sin_r;
   logic [2:0]    mode;
   logic [CW-1:0] amt;
   logic [W-1:0]  load_data, out;
   logic          sout_l, sout_r, busy, done;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] m_out;
   logic         m_sl, m_sr;
   logic [W+1:0] exp_q[$];

   universal_shift_reg #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .en(en), .start(start), .mode(mode), .amt(amt),
      .load_data(load_data), .sin_l(sin_l), .sin_r(sin_r), .out(out),
      .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference single-bit step, updates the model registers
   task automatic mstep(input logic [2:0] md);
      case (md)
         3'd0: begin m_sl = m_out[W-1]; m_out = {m_out[W-2:0], sin_l}; end
         3'd1: begin m_sr = m_out[0];   m_out = {sin_r, m_out[W-1:1]}; end
         3'd2: begin m_sl = m_out[W-1]; m_out = {m_out[W-2:0], m_out[W-1]}; end
         3'd3: begin m_sr = m_out[0];   m_out = {m_out[0], m_out[W-1:1]}; end
         3'd4: begin m_sr = m_out[0];   m_out = {m_out[W-1], m_out[W-1:1]}; end
         default: ;
      endcase
   endtask

   // Drive one command for one edge and queue the expected final state
   task automatic issue(input logic [2:0] md, input int am, input logic [W-1:0] ld);
      start = 1'b1; en = 1'b1; mode = md; amt = CW'(am); load_data = ld;
      if (md == 3'd5) m_out = ld;
      else if (md < 3'd5) for (int i = 0; i < am; i++) mstep(md);
      exp_q.push_back({m_sl, m_sr, m_out});
      tick();
      start = 1'b0; mode = 3'd7; amt = CW'(15); load_data = 8'hEE;
   endtask

   // Bounded wait for done, then compare against the queued expectation
   task automatic wait_done(input string tag);
      int n = 0;
      logic [W+1:0] e;
      while (!done && n < 100) begin tick(); n++; end
      tests++;
      if (n >= 100) begin
         fails++;
         $error("FAIL %s_timeout: observed done=0 expected done=1 within 100 cycles", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_out"},  32'(out), 32'(e[W-1:0]));
         chk({tag, "_sout"}, 32'({sout_l, sout_r}), 32'(e[W+1:W]));
         chk({tag, "_busy"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; start = 1'b0; mode = 3'd0; amt = '0;
      load_data = '0; sin_l = 1'b0; sin_r = 1'b0;
      m_out = '0; m_sl = 1'b0; m_sr = 1'b0;
      tick(); tick();
      chk("rst_out",  32'(out), 32'h0);
      chk("rst_flags", 32'({sout_l, sout_r, busy, done}), 32'h0);
      rstn = 1'b1;
      tick();

      // 1: LOAD A5, SHL 3 with sin_l=1, per-step values
      issue(3'd5, 0, 8'hA5);
      chk("t1_load_done", 32'(done), 32'd1);
      wait_done("t1_load");
      sin_l = 1'b1;
      issue(3'd0, 3, 8'h00);
      chk("t1_start_busy", 32'({busy, out}), 32'h1A5);
      tick(); chk("t1_s1", 32'({busy, done, out}), 32'h24B);
      tick(); chk("t1_s2", 32'({busy, done, out}), 32'h297);
      tick(); chk("t1_s3", 32'({busy, done, out}), 32'h12F);
      wait_done("t1_shl");
      chk("t1_sout_l", 32'(sout_l), 32'd1);
      tick(); chk("t1_done_pulse", 32'(done), 32'd0);

      // 2: ROR full turn, then ROL 1 issued while done is still high
      issue(3'd5, 0, 8'h81); wait_done("t2_load");
      issue(3'd3, 8, 8'h00); wait_done("t2_ror8");
      chk("t2_ror8_val", 32'(out), 32'h81);
      issue(3'd2, 1, 8'h00); wait_done("t2_rol1");
      chk("t2_rol1_val", 32'({sout_l, out}), 32'h103);

      // 3: ASR sign fill
      issue(3'd5, 0, 8'h90); wait_done("t3_load");
      issue(3'd4, 2, 8'h00);
      tick(); chk("t3_s1", 32'(out), 32'hC8);
      wait_done("t3_asr");
      chk("t3_val", 32'({sout_r, out}), 32'h0E4);

      // 4: SHR with a 3-cycle enable stall between steps
      issue(3'd5, 0, 8'hF0); wait_done("t4_load");
      sin_r = 1'b0;
      issue(3'd1, 2, 8'h00);
      tick(); chk("t4_s1", 32'(out), 32'h78);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t4_stall", 32'({busy, done, out}), 32'h278);
      end
      en = 1'b1;
      tick(); chk("t4_s2", 32'({busy, done, out}), 32'h13C);
      wait_done("t4_shr");
      tick(); chk("t4_single_done", 32'(done), 32'd0);

      // 5: start while busy ignored; amt=0 and reserved mode complete immediately
      sin_l = 1'b0;
      issue(3'd0, 2, 8'h00);
      start = 1'b1; mode = 3'd2; amt = CW'(5); load_data = 8'h11;
      tick();
      start = 1'b0;
      wait_done("t5_busy_ignore");
      chk("t5_val", 32'(out), 32'hF0);
      tick(); chk("t5_idle", 32'({busy, done}), 32'd0);
      issue(3'd0, 0, 8'h00);
      chk("t5_amt0", 32'({busy, done, out}), 32'h1F0);
      wait_done("t5_amt0");
      issue(3'd6, 3, 8'h00);
      chk("t5_resv", 32'({busy, done, out}), 32'h1F0);
      wait_done("t5_resv");
      start = 1'b1; en = 1'b0; mode = 3'd5; load_data = 8'h33;
      tick(); tick();
      start = 1'b0; en = 1'b1;
      chk("t5_en0_ignored", 32'({busy, done, out}), 32'h0F0);

      // 6: reset mid-SHIFT aborts without done; re-issued command completes
      issue(3'd5, 0, 8'h5A); wait_done("t6_load");
      issue(3'd2, 6, 8'h00);
      tick(); tick();
      rstn = 1'b0;
      #1;
      chk("t6_abort", 32'({busy, done, sout_l, sout_r, out}), 32'h0);
      void'(exp_q.pop_front());
      m_out = '0; m_sl = 1'b0; m_sr = 1'b0;
      #2 rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(); chk("t6_no_done", 32'({busy, done}), 32'd0);
      end
      issue(3'd5, 0, 8'h5A); wait_done("t6_reload");
      issue(3'd2, 6, 8'h00); wait_done("t6_rol6");
      chk("t6_val", 32'(out), 32'h96);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
